// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small power-of-two FIFO; frames are start, LSB-first data,
// optional parity and 1..2 stop bits. Define UART_TX_BREAK_EN to add i_uart_break (BREAK/MARK states).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | line high, waiting for a queued word (or a break request)
// S_START  | start bit (low) for one bit-time
// S_DATA   | N_DATA_BITS data bits, LSB first
// S_PARITY | parity bit, only when PARITY_MODE != 0
// S_STOP   | N_STOP_BITS high bit-times; chains straight into the next frame
// S_BREAK  | line held low while i_uart_break is high
// S_MARK   | line high for N_STOP_BITS bit-times after a break
module uart_tx_fifo #(
  parameter int N_DATA_BITS = 8,
  parameter int CLK_DIV     = 64,
  parameter int PARITY_MODE = 0,
  parameter int N_STOP_BITS = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          i_uart_clk,
  input  logic                          i_uart_reset,
  input  logic                          i_uart_data_valid,
  input  logic [N_DATA_BITS-1:0]        i_uart_data,
`ifdef UART_TX_BREAK_EN
  input  logic                          i_uart_break,
`endif
  output logic                          o_uart_ready,
  output logic                          o_uart_tx,
  output logic                          o_uart_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = $clog2(N_DATA_BITS);

  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(N_STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
`ifdef UART_TX_BREAK_EN
    S_BREAK  = 3'd5,
    S_MARK   = 3'd6,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [AW:0]            count_q, count_d;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [IW-1:0]          bit_idx_q, bit_idx_d;
  logic                   stop_idx_q, stop_idx_d;
  logic [N_DATA_BITS-1:0] shift_q, shift_d;
  logic                   parity_q, parity_d;
  logic                   tx_q, tx_d;
  logic [N_DATA_BITS-1:0] mem_q [FIFO_DEPTH];

  logic                   push;
  logic                   pop;
  logic                   fifo_empty;
  logic                   bit_last;
  logic [N_DATA_BITS-1:0] head;

  assign o_uart_ready = (count_q != FULL_CNT);
  assign o_fifo_count = count_q;
  assign o_uart_tx    = tx_q;
  assign push         = i_uart_data_valid && o_uart_ready;
  assign fifo_empty   = (count_q == '0);
  assign bit_last     = (bit_cnt_q == BIT_LAST);
  assign head         = mem_q[rd_ptr_q];

  // State register; reset wins over a same-edge push because the pointers and count are cleared.
  always_ff @(posedge i_uart_clk) begin
    if (i_uart_reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
    end
  end

  always_ff @(posedge i_uart_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_uart_data;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Next-state and frame datapath; a pop always (re)loads the shift register for a fresh START.
  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    bit_cnt_d  = bit_last ? '0 : bit_cnt_q + 1'b1;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    case (state_q)
      S_IDLE: begin
        bit_cnt_d = '0;
`ifdef UART_TX_BREAK_EN
        if (i_uart_break) state_d = S_BREAK;
        else
`endif
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_last) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        if (bit_last) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == IDX_LAST) begin
            stop_idx_d = 1'b0;
            state_d    = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (bit_last) begin
          stop_idx_d = 1'b0;
          state_d    = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_last) begin
          if (stop_idx_q != STOP_LAST) stop_idx_d = stop_idx_q + 1'b1;
`ifdef UART_TX_BREAK_EN
          else if (i_uart_break) state_d = S_BREAK;
`endif
          else if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      S_BREAK: begin
        bit_cnt_d = '0;
        if (!i_uart_break) begin
          stop_idx_d = 1'b0;
          state_d    = S_MARK;
        end
      end
      S_MARK: begin
        if (bit_last) begin
          if (stop_idx_q != STOP_LAST) stop_idx_d = stop_idx_q + 1'b1;
          else state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    if (pop) begin
      shift_d   = head;
      parity_d  = (PARITY_MODE == 2) ? ~^head : ^head;
      bit_idx_d = '0;
      bit_cnt_d = '0;
    end
  end

  // Line level follows the state one clock later through tx_q.
  always_comb begin
    tx_d        = 1'b1;
    o_uart_busy = (state_q != S_IDLE);
    case (state_q)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_q[0];
      S_PARITY: tx_d = parity_q;
`ifdef UART_TX_BREAK_EN
      S_BREAK:  tx_d = 1'b0;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four parameter sets driven together, a frame-position reference model,
// a table of frame vectors and hand sequences for FIFO-full, two stop bits, reset and break.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int NI = 4;
  localparam int P_N     [NI] = '{8, 8, 8, 5};
  localparam int P_DIV   [NI] = '{4, 4, 4, 3};
  localparam int P_PAR   [NI] = '{1, 2, 0, 2};
  localparam int P_STOP  [NI] = '{1, 1, 2, 2};
  localparam int P_DEPTH [NI] = '{4, 4, 4, 2};

  logic       clk;
  logic       rst;
  logic       vld;
  logic [7:0] din;
`ifdef UART_TX_BREAK_EN
  logic       brk;
`endif
  logic       tx   [NI];
  logic       busy [NI];
  logic       rdy  [NI];
  logic [2:0] cnt  [NI];

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [$clog2(P_DEPTH[g]):0] c;
    uart_tx_fifo #(
      .N_DATA_BITS(P_N[g]),
      .CLK_DIV    (P_DIV[g]),
      .PARITY_MODE(P_PAR[g]),
      .N_STOP_BITS(P_STOP[g]),
      .FIFO_DEPTH (P_DEPTH[g])
    ) u_dut (
      .i_uart_clk       (clk),
      .i_uart_reset     (rst),
      .i_uart_data_valid(vld),
      .i_uart_data      (din[P_N[g]-1:0]),
`ifdef UART_TX_BREAK_EN
      .i_uart_break     (brk),
`endif
      .o_uart_ready     (rdy[g]),
      .o_uart_tx        (tx[g]),
      .o_uart_busy      (busy[g]),
      .o_fifo_count     (c)
    );
    assign cnt[g] = 3'(c);
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Reference model: a queue of waiting words plus the position inside the frame on the wire.
  logic [7:0] mq [NI][$];
  bit         m_act [NI];
  logic [7:0] m_cur [NI];
  int         m_pos [NI];
  logic       m_tx  [NI];

  function automatic int flen(input int i);
    return P_DIV[i] * (1 + P_N[i] + ((P_PAR[i] != 0) ? 1 : 0) + P_STOP[i]);
  endfunction

  function automatic logic fbit(input int i, input logic [7:0] w, input int pos);
    int b;
    b = pos / P_DIV[i];
    if (b == 0) return 1'b0;
    if (b <= P_N[i]) return w[b-1];
    if (P_PAR[i] != 0 && b == P_N[i] + 1) return (P_PAR[i] == 1) ? ^w : ~^w;
    return 1'b1;
  endfunction

  task automatic model_step();
    for (int i = 0; i < NI; i++) begin
      logic       line;
      bit         push;
      logic [7:0] mask;
      if (rst) begin
        mq[i].delete();
        m_act[i] = 0;
        m_pos[i] = 0;
        m_tx[i]  = 1'b1;
      end else begin
        line = m_act[i] ? fbit(i, m_cur[i], m_pos[i]) : 1'b1;
        push = vld && (mq[i].size() != P_DEPTH[i]);
        mask = 8'((1 << P_N[i]) - 1);
        if (m_act[i]) begin
          if (m_pos[i] == flen(i) - 1) begin
            if (mq[i].size() > 0) begin
              m_cur[i] = mq[i].pop_front();
              m_pos[i] = 0;
            end else begin
              m_act[i] = 0;
            end
          end else begin
            m_pos[i]++;
          end
        end else if (mq[i].size() > 0) begin
          m_act[i] = 1;
          m_cur[i] = mq[i].pop_front();
          m_pos[i] = 0;
        end
        if (push) mq[i].push_back(din & mask);
        m_tx[i] = line;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("cyc_tx%0d", i), tx[i], m_tx[i]);
        chk($sformatf("cyc_busy%0d", i), busy[i], m_act[i]);
        chk($sformatf("cyc_cnt%0d", i), cnt[i], mq[i].size());
        chk($sformatf("cyc_rdy%0d", i), rdy[i], (mq[i].size() != P_DEPTH[i]) ? 1 : 0);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    vld = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at the negedge right after the start-bit edge; samples each bit in its second clock.
  task automatic sample_frames(input logic [10:0] e0, input logic [10:0] e1, input logic [10:0] e2,
                               input bit [2:0] en);
    for (int k = 0; k < 11; k++) begin
      repeat ((k == 0) ? 1 : 4) @(posedge clk);
      @(negedge clk);
      if (en[0]) chk($sformatf("bit_i0_k%0d", k), tx[0], e0[k]);
      if (en[1]) chk($sformatf("bit_i1_k%0d", k), tx[1], e1[k]);
      if (en[2]) chk($sformatf("bit_i2_k%0d", k), tx[2], e2[k]);
    end
  endtask

  task automatic send_check(input logic [7:0] w, input logic pe, input logic po, input bit brk_mid);
    logic [10:0] e0, e1, e2;
    e0 = {1'b1, pe, w, 1'b0};
    e1 = {1'b1, po, w, 1'b0};
    e2 = {2'b11, w, 1'b0};
    @(negedge clk);
    vld = 1'b1;
    din = w;
    @(posedge clk);
    @(negedge clk);
    vld = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("pre_start_high", tx[0], 1);
`ifdef UART_TX_BREAK_EN
    if (brk_mid) brk = 1'b1;
`endif
    @(posedge clk);
    @(negedge clk);
    chk("start_i0", tx[0], 0);
    chk("start_i1", tx[1], 0);
    chk("start_i2", tx[2], 0);
    sample_frames(e0, e1, e2, brk_mid ? 3'b001 : 3'b111);
    @(posedge clk);
    @(negedge clk);
    chk("busy_last_clk", busy[0], 1);
    @(posedge clk);
    @(negedge clk);
    chk("busy_after_frame", busy[0], brk_mid ? 1 : 0);
    if (!brk_mid) chk("busy_after_frame_i2", busy[2], 0);
  endtask

  typedef struct {
    logic [7:0] w;
    logic       pe;
    logic       po;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int hi, falls, highs, lows, bad, guard;
    bit prev;
    rst = 1'b1;
    vld = 1'b0;
    din = 8'h00;
`ifdef UART_TX_BREAK_EN
    brk = 1'b0;
`endif
    vecs[0] = '{8'hA5, 1'b0, 1'b1};
    vecs[1] = '{8'h01, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 1'b0, 1'b1};
    vecs[3] = '{8'h80, 1'b1, 1'b0};
    vecs[4] = '{8'h3C, 1'b0, 1'b1};
    vecs[5] = '{8'h07, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1;
    chk("rst_tx", tx[0], 1);
    chk("rst_busy", busy[0], 0);
    chk("rst_ready", rdy[0], 1);
    chk("rst_count", cnt[0], 0);

    for (int v = 0; v < 6; v++) begin
      do_reset();
      send_check(vecs[v].w, vecs[v].pe, vecs[v].po, 1'b0);
    end

    // Reset and push on the same edge: the push is dropped.
    @(negedge clk);
    rst = 1'b1;
    vld = 1'b1;
    din = 8'h77;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    vld = 1'b0;
    chk("rst_push_count", cnt[0], 0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_push_busy", busy[0], 0);

    // Valid held six cycles into a 4-deep FIFO.
    do_reset();
    hi = 0;
    falls = 0;
    prev = 0;
    for (int c = 0; c < 450; c++) begin
      @(negedge clk);
      if (busy[0]) hi++;
      if (prev && !busy[0]) falls++;
      prev = busy[0];
      if (c < 6) begin
        vld = 1'b1;
        din = 8'(8'h10 + c);
        chk($sformatf("burst_ready_%0d", c), rdy[0], (c < 5) ? 1 : 0);
      end else begin
        vld = 1'b0;
      end
      @(posedge clk);
    end
    chk("burst_busy_clks", hi, 220);
    chk("burst_busy_falls", falls, 1);

    // Two stop bits, two queued words: exactly 2*CLK_DIV high clocks between frames.
    do_reset();
    @(negedge clk);
    vld = 1'b1;
    din = 8'h43;
    @(posedge clk);
    @(negedge clk);
    din = 8'h3C;
    @(posedge clk);
    @(negedge clk);
    vld = 1'b0;
    repeat (36) @(posedge clk);
    @(negedge clk);
    chk("stop2_last_data", tx[2], 0);
    @(posedge clk);
    highs = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (tx[2]) highs++;
      @(posedge clk);
    end
    @(negedge clk);
    chk("stop2_high_clks", highs, 8);
    chk("stop2_next_start", tx[2], 0);

    // Reset during DATA bit 3 with two words queued.
    do_reset();
    @(negedge clk);
    vld = 1'b1;
    din = 8'h11;
    @(posedge clk);
    @(negedge clk);
    din = 8'h22;
    @(posedge clk);
    @(negedge clk);
    din = 8'h33;
    @(posedge clk);
    @(negedge clk);
    vld = 1'b0;
    repeat (16) @(posedge clk);
    @(negedge clk);
    chk("midrst_queued", cnt[0], 2);
    chk("midrst_busy_before", busy[0], 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("midrst_tx%0d", i), tx[i], 1);
      chk($sformatf("midrst_busy%0d", i), busy[i], 0);
      chk($sformatf("midrst_cnt%0d", i), cnt[i], 0);
    end
    bad = 0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (!tx[0] || busy[0]) bad++;
    end
    chk("midrst_quiet", bad, 0);

`ifdef UART_TX_BREAK_EN
    // Break raised in mid-frame: frame completes, line low, mark, then the queued word.
    do_reset();
    chk_en = 0;
    send_check(8'h5A, 1'b0, 1'b1, 1'b1);
    vld = 1'b1;
    din = 8'h33;
    @(posedge clk);
    @(negedge clk);
    vld = 1'b0;
    chk("brk_push_count", cnt[0], 1);
    lows = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (!tx[0]) lows++;
    end
    chk("brk_line_low", lows, 16);
    chk("brk_busy", busy[0], 1);
    brk = 1'b0;
    guard = 0;
    while (!tx[0] && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    highs = 0;
    while (tx[0] && highs < 50) begin
      highs++;
      @(negedge clk);
    end
    chk("brk_mark_len_ok", (highs >= 4 && highs <= 6) ? 1 : 0, 1);
    sample_frames({1'b1, 1'b0, 8'h33, 1'b0}, 11'h0, 11'h0, 3'b001);
    do_reset();
    chk_en = 1;
`endif

    // Randomized traffic with occasional resets, checked cycle by cycle against the model.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      vld = ($urandom_range(0, 2) == 0);
      din = 8'($urandom);
      rst = ($urandom_range(0, 499) == 0);
    end
    @(negedge clk);
    vld = 1'b0;
    rst = 1'b0;
    repeat (300) @(posedge clk);
    @(negedge clk);
    chk("drain_idle", busy[0], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
